// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz step-count accelerator.
package collatz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOOP,
        ST_EXIT,
        ST_DONE
    } state_e;

    localparam int STG_A   = 0;
    localparam int STG_B   = 1;
    localparam int LOOP_II = 2;

endpackage

// File: rtl/collatz_step_unit.sv
// One combinational Collatz map step: next value, parity and 3x+1 overflow flag.
module collatz_step_unit
    import collatz_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] nxt,
    output logic              par,
    output logic              ovf
);

    localparam logic [DATA_W+1:0] ONE = (DATA_W+2)'(1);

    logic [DATA_W+1:0] cur_ext;
    logic [DATA_W+1:0] triple_p1;

    // Two guard bits are enough: 3*(2^W-1)+1 < 2^(W+2).
    assign cur_ext   = {2'b00, cur};
    assign triple_p1 = (cur_ext << 1) + cur_ext + ONE;

    assign par = cur[0];
    assign ovf = par & (|triple_p1[DATA_W+1:DATA_W]);
    assign nxt = par ? triple_p1[DATA_W-1:0] : (cur >> 1);

endmodule

// File: rtl/collatz_pipe.sv
// Restartable Collatz step counter with a 2-stage (II=2) loop, overflow and step-limit aborts.
// Optional `peak` output (running maximum) is enabled by defining COLLATZ_PEAK_EN.
module collatz_pipe
    import collatz_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              STEP_W    = 32,
    parameter longint unsigned MAX_STEPS = (64'd1 << STEP_W) - 64'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] n,
    output logic              busy,
    output logic              finish,
    output logic [STEP_W-1:0] ret0,
    output logic              ovf,
    output logic              timeout
`ifdef COLLATZ_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak
`endif
);

    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);
    localparam logic [DATA_W-1:0] ONE_D    = DATA_W'(1);

    state_e               state_q, state_d;
    logic [LOOP_II-1:0]   vld_pipe, vld_d;
    logic [DATA_W-1:0]    n_q;
    logic [DATA_W-1:0]    cur_q;
    logic [DATA_W-1:0]    nxt_q;
    logic [STEP_W-1:0]    step_q;
    logic [STEP_W-1:0]    step_inc;
    logic [DATA_W-1:0]    su_nxt;
    logic                 su_par;
    logic                 su_ovf;
    logic                 stg_a, stg_b;

    collatz_step_unit #(.DATA_W(DATA_W)) u_step (
        .cur (cur_q),
        .nxt (su_nxt),
        .par (su_par),
        .ovf (su_ovf)
    );

    assign stg_a    = (state_q == ST_LOOP) && vld_pipe[STG_A];
    assign stg_b    = (state_q == ST_LOOP) && vld_pipe[STG_B];
    assign step_inc = step_q + STEP_W'(1);
    assign busy     = (state_q != ST_IDLE);
    assign finish   = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        vld_d   = '0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_INIT;
            ST_INIT: begin
                if (n_q > ONE_D) begin
                    state_d      = ST_LOOP;
                    vld_d[STG_A] = 1'b1;
                end else begin
                    state_d = ST_EXIT;
                end
            end
            ST_LOOP: begin
                if (vld_pipe[STG_A]) begin
                    // Overflow aborts before stage B and before the step is counted.
                    if (su_ovf) state_d = ST_EXIT;
                    else        vld_d[STG_B] = 1'b1;
                end else if (vld_pipe[STG_B]) begin
                    if (timeout || (nxt_q <= ONE_D)) state_d = ST_EXIT;
                    else                             vld_d[STG_A] = 1'b1;
                end else begin
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vld_pipe <= '0;
            n_q      <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            step_q   <= '0;
            ret0     <= '0;
            ovf      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_pipe <= vld_d;
            if (state_q == ST_IDLE && start) n_q <= n;
            if (state_q == ST_INIT) begin
                cur_q   <= n_q;
                step_q  <= '0;
                ovf     <= 1'b0;
                timeout <= 1'b0;
            end
            if (stg_a) begin
                if (su_ovf) begin
                    ovf <= 1'b1;
                end else begin
                    nxt_q  <= su_nxt;
                    step_q <= step_inc;
                    if (step_inc == STEP_MAX) timeout <= 1'b1;
                end
            end
            if (stg_b) cur_q <= nxt_q;
            if (state_q == ST_EXIT) ret0 <= step_q;
        end
    end

`ifdef COLLATZ_PEAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (state_q == ST_INIT) begin
            peak <= n_q;
        end else if (stg_b && (nxt_q > peak)) begin
            peak <= nxt_q;
        end
    end
`endif

endmodule

// File: tb/tb_collatz_pipe.sv
// Scoreboard bench: three collatz_pipe configurations (32-bit, 8-bit, step limit 10)
// checked against a plain-arithmetic Collatz reference model.
module tb_collatz_pipe;

    typedef struct packed {
        logic [31:0] ret;
        logic        ovf;
        logic        to;
        logic [31:0] peak;
        logic [31:0] fin_cyc;
        logic [31:0] lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_v [3];
    logic [31:0] n_v     [3];
    logic        busy_v  [3];
    logic        fin_v   [3];
    logic [31:0] ret_v   [3];
    logic        ovf_v   [3];
    logic        to_v    [3];
    logic [31:0] peak_v  [3];
    logic [7:0]  peak1;

    int   cyc;
    int   tests;
    int   fails;
    exp_t q [3][$];

    collatz_pipe u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .n(n_v[0]),
        .busy(busy_v[0]), .finish(fin_v[0]), .ret0(ret_v[0]), .ovf(ovf_v[0]), .timeout(to_v[0])
`ifdef COLLATZ_PEAK_EN
        , .peak(peak_v[0])
`endif
    );

    collatz_pipe #(.DATA_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .n(n_v[1][7:0]),
        .busy(busy_v[1]), .finish(fin_v[1]), .ret0(ret_v[1]), .ovf(ovf_v[1]), .timeout(to_v[1])
`ifdef COLLATZ_PEAK_EN
        , .peak(peak1)
`endif
    );

    collatz_pipe #(.MAX_STEPS(10)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .n(n_v[2]),
        .busy(busy_v[2]), .finish(fin_v[2]), .ret0(ret_v[2]), .ovf(ovf_v[2]), .timeout(to_v[2])
`ifdef COLLATZ_PEAK_EN
        , .peak(peak_v[2])
`endif
    );

`ifdef COLLATZ_PEAK_EN
    assign peak_v[1] = {24'd0, peak1};
`else
    assign peak1 = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: iterate the map directly; an odd value whose 3x+1 does not fit aborts.
    function automatic exp_t model(input longint unsigned nv, input int w, input longint unsigned maxs);
        exp_t e;
        longint unsigned cur, pk, st;
        bit stop;
        e = '0;
        cur = nv; pk = nv; st = 0; stop = 0;
        while (cur > 1 && !stop) begin
            if ((cur % 2 == 1) && (3 * cur + 1 >= (64'd1 << w))) begin
                e.ovf = 1'b1;
                stop = 1;
            end else begin
                cur = (cur % 2 == 1) ? 3 * cur + 1 : cur / 2;
                st++;
                if (cur > pk) pk = cur;
                if (st == maxs) begin
                    e.to = 1'b1;
                    stop = 1;
                end
            end
        end
        e.ret  = 32'(st);
        e.peak = 32'(pk);
        e.lat  = e.ovf ? 32'(4 + 2 * st) : 32'(3 + 2 * st);
        return e;
    endfunction

    task automatic run_job(input int k, input logic [31:0] nv, input bit junk);
        exp_t e;
        int   w;
        @(negedge clk);
        w = 0;
        while (busy_v[k] && w < 3000) begin
            w++;
            @(negedge clk);
        end
        if (busy_v[k]) begin
            chk("idle_wait", 64'(busy_v[k]), 64'd0);
            return;
        end
        e = model(64'(nv), (k == 1) ? 8 : 32, (k == 2) ? 64'd10 : 64'hFFFF_FFFF);
        e.fin_cyc = 32'(cyc) + e.lat;
        q[k].push_back(e);
        start_v[k] = 1'b1;
        n_v[k]     = nv;
        @(negedge clk);
        start_v[k] = 1'b0;
        n_v[k]     = $urandom;
        if (junk) begin
            // A start during a running job must be dropped, not queued.
            repeat (2) @(negedge clk);
            start_v[k] = 1'b1;
            @(negedge clk);
            start_v[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (fin_v[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    chk("unexpected_finish", 64'(k), 64'd99);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    chk("ret0",    64'(ret_v[k]), 64'(e.ret));
                    chk("ovf",     64'(ovf_v[k]), 64'(e.ovf));
                    chk("timeout", 64'(to_v[k]),  64'(e.to));
                    chk("latency", 64'(cyc),      64'(e.fin_cyc));
`ifdef COLLATZ_PEAK_EN
                    chk("peak",    64'(peak_v[k]), 64'(e.peak));
`endif
                end
            end
        end
    end

    task automatic chk_zero(input int k);
        chk("rst_busy",    64'(busy_v[k]), 64'd0);
        chk("rst_finish",  64'(fin_v[k]),  64'd0);
        chk("rst_ret0",    64'(ret_v[k]),  64'd0);
        chk("rst_ovf",     64'(ovf_v[k]),  64'd0);
        chk("rst_timeout", 64'(to_v[k]),   64'd0);
`ifdef COLLATZ_PEAK_EN
        chk("rst_peak",    64'(peak_v[k]), 64'd0);
`endif
    endtask

    initial begin
        int w;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            n_v[k]     = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_zero(k);
        rst_n = 1'b1;

        run_job(0, 32'd1, 0);
        run_job(0, 32'd6, 0);
        run_job(0, 32'd27, 1);
        run_job(0, 32'd0, 0);      // issued the cycle after the previous finish
        run_job(1, 32'd171, 0);
        run_job(2, 32'd27, 0);
        run_job(0, 32'd6, 0);      // leaves ret0 non-zero before the reset test

        // Drain, then abort a job mid-loop with an asynchronous reset.
        w = 0;
        while (q[0].size() != 0 && w < 3000) begin w++; @(negedge clk); end
        run_job(0, 32'd27, 0);
        repeat (38) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero(0);
        q[0].delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        run_job(0, 32'd6, 0);

        for (int i = 0; i < 12; i++) run_job(0, $urandom_range(0, 3000), (i % 3) == 0);
        for (int i = 0; i < 4; i++)  run_job(0, $urandom, 0);
        for (int i = 0; i < 15; i++) run_job(1, $urandom_range(0, 255), 0);
        for (int i = 0; i < 10; i++) run_job(2, $urandom_range(0, 500), (i % 4) == 1);

        w = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && w < 5000) begin
            w++;
            @(negedge clk);
        end
        chk("drain", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
